// File: rtl/conv_window_feeder.sv
// conv_window_feeder: CHANNELS x TAPS sliding sample window feeding a conv engine.
// Optional CONV_FEEDER_SNAPSHOT_EN: snapshot bank freezes o_data so sampling never stalls.
module conv_window_feeder #(
  parameter int CHANNELS = 8,
  parameter int TAPS     = 5,
  parameter int DW       = 16,
  parameter int STRIDE   = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_sample,
  output logic          o_ready,
  input  logic          i_flush,
  output logic [DW-1:0] o_data [0:CHANNELS*TAPS-1],
  output logic          o_start,
  input  logic          i_finished,
  output logic          o_busy,
  output logic [15:0]   o_frames
);
  localparam int N  = CHANNELS * TAPS;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int FW = $clog2(TAPS + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] ch;
  logic [FW-1:0] fill;
  logic [FW-1:0] since;
  logic [DW-1:0] stage [0:CHANNELS-1];
  logic [DW-1:0] win [0:N-1];
  logic          fin_q;
  logic          accept;
  logic          frame_done;
  logic          eligible;
  logic          rise;

  assign eligible   = (fill == FW'(TAPS)) && (since == FW'(STRIDE));
  assign rise       = i_finished && !fin_q;
  assign accept     = i_valid && o_ready && !i_flush;
  assign frame_done = accept && (ch == CW'(CHANNELS - 1));

`ifdef CONV_FEEDER_SNAPSHOT_EN
  assign o_ready = 1'b1;
`else
  assign o_ready = (state == IDLE) && !eligible;
`endif

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next state and handshake outputs
  always_comb begin
    state_nx = state;
    o_start  = 1'b0;
    o_busy   = 1'b0;
    unique case (state)
      IDLE: begin
        if (eligible) state_nx = START;
      end
      START: begin
        o_start  = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        o_busy = 1'b1;
        if (rise) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // finished history for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) fin_q <= 1'b0;
    else          fin_q <= i_finished;
  end

  // channel position, fill level, stride count and staging
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      ch    <= '0;
      fill  <= '0;
      since <= '0;
      for (int c = 0; c < CHANNELS; c++) stage[c] <= '0;
    end else begin
      if (accept) begin
        stage[ch] <= i_sample;
        ch        <= frame_done ? '0 : ch + 1'b1;
      end
      if (frame_done && fill != FW'(TAPS)) fill <= fill + 1'b1;
      if (state == START)
        since <= frame_done ? FW'(1) : '0;
      else if (frame_done && since != FW'(STRIDE))
        since <= since + 1'b1;
    end
  end

  // live window shift and frame counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_frames <= '0;
      for (int i = 0; i < N; i++) win[i] <= '0;
    end else if (frame_done) begin
      o_frames <= o_frames + 16'd1;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int t = 0; t < TAPS - 1; t++)
          win[c*TAPS+t] <= win[c*TAPS+t+1];
        win[c*TAPS+TAPS-1] <= (c == CHANNELS - 1) ? i_sample : stage[c];
      end
    end
  end

`ifdef CONV_FEEDER_SNAPSHOT_EN
  logic [DW-1:0] snap [0:N-1];

  // capture the eligible window on entry to START
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) snap[i] <= '0;
    end else if (state == IDLE && eligible) begin
      snap <= win;
    end
  end

  assign o_data = snap;
`else
  assign o_data = win;
`endif

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: table vectors plus start-event scoreboard.
// Instance a uses STRIDE=1, instance b uses STRIDE=2.
module tb_conv_window_feeder;
`ifdef CONV_FEEDER_SNAPSHOT_EN
  localparam logic WR = 1'b1;
`else
  localparam logic WR = 1'b0;
`endif

  typedef logic [39:0][15:0] win_t;
  typedef struct packed {
    logic [15:0] frames;
    win_t        win;
  } exp_t;
  typedef struct {
    logic fin;
    logic busy;
    logic start;
    logic ready;
  } fvec_t;
  typedef struct {
    int   f;
    logic start;
    int   frames;
  } svec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 0, a_flush = 0, a_fin = 0;
  logic [15:0] a_sample = 0;
  logic        a_ready, a_start, a_busy;
  logic [15:0] a_frames;
  logic [15:0] a_data [0:39];

  logic        b_valid = 0, b_flush = 0, b_fin = 0;
  logic [15:0] b_sample = 0;
  logic        b_ready, b_start, b_busy;
  logic [15:0] b_frames;
  logic [15:0] b_data [0:39];

  conv_window_feeder u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(a_valid), .i_sample(a_sample),
    .o_ready(a_ready), .i_flush(a_flush),
    .o_data(a_data), .o_start(a_start),
    .i_finished(a_fin), .o_busy(a_busy),
    .o_frames(a_frames)
  );

  conv_window_feeder #(.STRIDE(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(b_valid), .i_sample(b_sample),
    .o_ready(b_ready), .i_flush(b_flush),
    .o_data(b_data), .o_start(b_start),
    .i_finished(b_fin), .o_busy(b_busy),
    .o_frames(b_frames)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int a_starts = 0;
  logic [15:0] mwin [0:39];
  int mframes = 0;
  exp_t sbq[$];
  exp_t mon_e;
  fvec_t ftbl [14];
  svec_t stbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input win_t w);
    int bad;
    bad = -1;
    for (int i = 39; i >= 0; i--) if (a_data[i] !== w[i]) bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s: o_data[%0d]=%h, expected %h", name, bad, a_data[bad], w[bad]);
    end
  endtask

  function automatic win_t pack_m();
    win_t w;
    for (int i = 0; i < 40; i++) w[i] = mwin[i];
    return w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 40; i++) mwin[i] = '0;
    mframes = 0;
  endtask

  task automatic expect_start();
    exp_t e;
    e.frames = 16'(mframes);
    e.win = pack_m();
    sbq.push_back(e);
  endtask

  task automatic put(input bit b, input logic [15:0] s);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    if (b) begin b_valid = 1; b_sample = s; end
    else begin a_valid = 1; a_sample = s; end
    while (!acc && n < 200) begin
      acc = b ? b_ready : a_ready;
      @(posedge clk); #1;
      n++;
    end
    a_valid = 0;
    b_valid = 0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL put_timeout: ready low for 200 cycles, expected high");
    end
  endtask

  task automatic frame(input bit b, input int f);
    for (int c = 0; c < 8; c++) put(b, 16'(c*16 + f));
    if (!b) begin
      for (int c = 0; c < 8; c++) begin
        for (int t = 0; t < 4; t++) mwin[c*5+t] = mwin[c*5+t+1];
        mwin[c*5+4] = 16'(c*16 + f);
      end
      mframes++;
    end
  endtask

  task automatic wait_start();
    bit seen;
    int n;
    seen = 0;
    n = 0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      seen = a_start;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL start_timeout: no o_start within 30 cycles, expected one");
    end
  endtask

  // scoreboard: every start must match a queued expectation
  always @(negedge clk) begin
    if (rst_n && a_start) begin
      a_starts++;
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_start: start at frames=%0d, expected none", a_frames);
      end else begin
        mon_e = sbq.pop_front();
        chk("start_frames", a_frames, mon_e.frames);
        chk_win("start_window", mon_e.win);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    bit seen;
    int stall_bad;
    win_t ws;

    for (int i = 0; i < 14; i++) begin
      ftbl[i].fin   = (i >= 1 && i <= 10);
      ftbl[i].busy  = (i == 0);
      ftbl[i].start = 1'b0;
      ftbl[i].ready = (i == 0) ? WR : 1'b1;
    end
    for (int i = 0; i < 9; i++) begin
      stbl[i].f      = i + 1;
      stbl[i].start  = (i == 4 || i == 6 || i == 8);
      stbl[i].frames = i + 1;
    end
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", a_ready, 1);
    chk("reset_start", a_start, 0);
    chk("reset_busy", a_busy, 0);
    chk("reset_frames", a_frames, 0);
    chk_win("reset_data", '0);
    @(posedge clk); #1;
    rst_n = 1;

    for (int f = 0; f < 5; f++) frame(0, f);
`ifndef CONV_FEEDER_SNAPSHOT_EN
    chk_win("window_after_5", pack_m());
`endif
    chk("frames_after_5", a_frames, 5);
    expect_start();
    @(negedge clk);
    chk("start_not_early", a_start, 0);
    @(negedge clk);
    chk("start_next_cycle", a_start, 1);
    chk("busy_in_start", a_busy, 0);
    @(negedge clk);
    chk("start_one_cycle", a_start, 0);
    chk("busy_in_wait", a_busy, 1);

    for (int i = 0; i < 14; i++) begin
      a_fin = ftbl[i].fin;
      @(posedge clk); #1;
      chk($sformatf("fin_row%0d_busy", i), a_busy, ftbl[i].busy);
      chk($sformatf("fin_row%0d_start", i), a_start, ftbl[i].start);
      chk($sformatf("fin_row%0d_ready", i), a_ready, ftbl[i].ready);
    end
    chk("single_start", a_starts, 1);

    frame(0, 5);
    expect_start();
    wait_start();
    @(posedge clk); #1;
`ifdef CONV_FEEDER_SNAPSHOT_EN
    ws = pack_m();
    frame(0, 6);
    frame(0, 7);
    chk("snap_frames", a_frames, 8);
    chk("snap_busy", a_busy, 1);
    chk_win("snap_hold", ws);
    expect_start();
    a_fin = 1;
    @(posedge clk); #1;
    a_fin = 0;
    chk("snap_idle_busy", a_busy, 0);
    chk("snap_idle_start", a_start, 0);
    @(posedge clk); #1;
    chk("snap_restart", a_start, 1);
    @(posedge clk); #1;
    a_fin = 1;
    @(posedge clk); #1;
    a_fin = 0;
    chk("snap_done_busy", a_busy, 0);
`else
    a_valid = 1;
    a_sample = 16'hBEEF;
    stall_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_ready !== 1'b0) stall_bad++;
    end
    a_valid = 0;
    chk("stall_ready", stall_bad, 0);
    chk("stall_frames", a_frames, 6);
    chk_win("stall_window", pack_m());
    a_fin = 1;
    @(posedge clk); #1;
    a_fin = 0;
    chk("stall_done_busy", a_busy, 0);
    chk("stall_no_accept", a_frames, 6);
`endif

    frame(0, 8);
    expect_start();
    wait_start();
    @(posedge clk); #1;
    chk("pre_reset_busy", a_busy, 1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("midwait_reset_busy", a_busy, 0);
    chk("midwait_reset_frames", a_frames, 0);
    chk("midwait_reset_ready", a_ready, 1);
    chk_win("midwait_reset_data", '0);
    model_clear();

    for (int f = 0; f < 4; f++) frame(0, f);
    for (int c = 0; c < 3; c++) put(0, 16'(c*16 + 4));
    a_flush = 1;
    a_valid = 1;
    a_sample = 16'h7777;
    @(posedge clk); #1;
    a_flush = 0;
    a_valid = 0;
    chk("flush_frames", a_frames, 4);
`ifndef CONV_FEEDER_SNAPSHOT_EN
    chk_win("flush_keeps_data", pack_m());
`endif
    s0 = a_starts;
    for (int f = 10; f < 14; f++) frame(0, f);
    repeat (3) @(negedge clk);
    chk("no_start_4_fresh", a_starts, s0);
    frame(0, 14);
    expect_start();
    wait_start();
    @(posedge clk); #1;
    a_fin = 1;
    @(posedge clk); #1;
    a_fin = 0;
    chk("flush_done_busy", a_busy, 0);

    for (int i = 0; i < 9; i++) begin
      frame(1, stbl[i].f);
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (b_start) seen = 1;
      end
      chk($sformatf("stride_start_f%0d", stbl[i].f), seen, stbl[i].start);
      chk($sformatf("stride_frames_f%0d", stbl[i].f), b_frames, stbl[i].frames);
      if (seen) begin
        @(posedge clk); #1;
        b_fin = 1;
        @(posedge clk); #1;
        b_fin = 0;
      end
    end
    chk("stride_busy_end", b_busy, 0);
    chk("stride_newest", b_data[39], 7*16 + 9);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
